calc_sched: RTL and testbench
=============================

Name: calc_sched

Overview:
- Tile sequencer for the A*S multiply datapath (calc_unit). Accepts a job command: weight vector S, base address, tile count.
- Per tile: fetches one 8x4x64 A tile from tile memory, pulses calc_unit start, waits the fixed compute latency, captures Y, hands it downstream over valid/ready.
- Processes one tile at a time, with no overlap. Sits between the host/DMA command path and calc_unit.

Parameters:
- ADDR_W, 10, tile memory address width (tile-granular).
- CNT_W, 10, width of the tile count field.
- CALC_LAT, 4, cycles from the calc_start cycle until calc_result is valid. Must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  job command valid
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  ADDR_W  address of first A tile
- cmd_ntiles  in  CNT_W  number of tiles; 0 is legal
- cmd_weight  in  160  S vector, latched at accept
- a_rd_en  out  1  tile memory read strobe
- a_rd_addr  out  ADDR_W  tile address
- a_rd_data  in  [7:0][3:0][63:0]  read data, valid 1 cycle after a_rd_en
- calc_start  out  1  one-cycle start pulse to calc_unit
- calc_weight  out  160  latched S, held for the whole job
- calc_data  out  [7:0][3:0][63:0]  latched A tile, held stable from START until next FETCH
- calc_result  in  [7:0][3:0][16:0]  Y from calc_unit
- res_valid  out  1  result valid
- res_ready  in  1  downstream ready
- res_data  out  [7:0][3:0][16:0]  captured Y
- res_idx  out  CNT_W  tile index of res_data, 0-based
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready, which is 1.
  - All internal registers are cleared.
  - Reset mid-job abandons the job. No done pulse, no further reads or results.
- States: IDLE, FETCH, WAIT_RD, START, COMPUTE, OUT, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch base into addr_q, ntiles, weight; clear tile index.
  - If ntiles==0 go to FIN, otherwise go to FETCH.
- FETCH (1 cycle): a_rd_en=1, a_rd_addr=addr_q. Go to WAIT_RD.
- WAIT_RD (1 cycle): latch a_rd_data into calc_data. Go to START.
- START (1 cycle): calc_start=1. Load the latency counter with CALC_LAT-1. Go to COMPUTE.
- COMPUTE (CALC_LAT cycles):
  - Decrement the counter each cycle.
  - On the cycle the counter is 0, capture calc_result into res_data. Go to OUT.
- OUT:
  - res_valid=1. res_data and res_idx are held stable while res_ready is low (unbounded backpressure).
  - On handshake: increment index and addr_q.
  - Go to FETCH if index+1<ntiles, otherwise go to FIN.
- FIN (1 cycle): done=1. Go to IDLE.
- Address arithmetic: addr_q wraps modulo 2^ADDR_W.
- Index arithmetic: index compare is CNT_W-bit unsigned. ntiles=2^CNT_W-1 is the maximum.
- Throughput: per tile with res_ready held high = CALC_LAT+4 cycles.
- Commands: never accepted while busy. cmd_valid in non-IDLE states is ignored; the command must be held by the sender.
- calc_weight is updated only at command accept.

Decomposition:
- Package calc_pkg holds:
  - localparams: ROWS=8, COLS=4, A_W=64, Y_W=17, S_W=160
  - typedefs: a_tile_t ([7:0][3:0][63:0]), y_tile_t ([7:0][3:0][16:0])
  - state enum sched_state_e
- No sub-module. Single FSM plus datapath registers.
- calc_top instantiates calc_sched and calc_unit side by side.

Test Plan:
- Reset: rst_n=0 for 2 cycles → cmd_ready=1; busy, done, res_valid, calc_start, a_rd_en all 0.
- Basic job, CALC_LAT=4, accept at c0 with base=0x10, ntiles=3, res_ready=1:
  - a_rd_addr 0x10 at c1, 0x11 at c9, 0x12 at c17.
  - res_idx 0/1/2 handshakes at c8/c16/c24; done pulse at c25; cmd_ready=1 at c26.
  - Scoreboard checks res_data against a golden A*S model.
- Zero tiles: ntiles=0 → done at c0+1, with no a_rd_en, calc_start or res_valid ever asserted.
- Backpressure: res_ready=0 for 10 cycles in OUT of tile 0 → res_valid stays 1, res_data and res_idx stable, no a_rd_en. Next FETCH occurs on the cycle after the handshake.
- Wrap and busy: base=2^ADDR_W-1, ntiles=2 → addresses 0x3FF then 0x000. cmd_valid pulsed mid-job → ignored, cmd_ready=0.
- Reset mid-COMPUTE: rst_n=0 during tile 1 → next cycle IDLE, outputs cleared, no done pulse. A new job afterward runs correctly from index 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types for the calc tile sequencer: tile shapes, operand widths and
// the scheduler state encoding.
package calc_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 4;
  localparam int A_W  = 64;
  localparam int Y_W  = 17;
  localparam int S_W  = 160;

  typedef logic [ROWS-1:0][COLS-1:0][A_W-1:0] a_tile_t;
  typedef logic [ROWS-1:0][COLS-1:0][Y_W-1:0] y_tile_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT_RD = 3'd2,
    S_START   = 3'd3,
    S_COMPUTE = 3'd4,
    S_OUT     = 3'd5,
    S_FIN     = 3'd6
  } sched_state_e;

endpackage

// File: rtl/calc_sched.sv
// Tile sequencer for calc_unit: fetch one A tile, start the multiply, wait the
// fixed latency, then hand the captured Y downstream before the next tile.
module calc_sched
  import calc_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 10,
  parameter int CALC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [CNT_W-1:0]  cmd_ntiles,
  input  logic [S_W-1:0]    cmd_weight,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  a_tile_t           a_rd_data,
  output logic              calc_start,
  output logic [S_W-1:0]    calc_weight,
  output a_tile_t           calc_data,
  input  y_tile_t           calc_result,
  output logic              res_valid,
  input  logic              res_ready,
  output y_tile_t           res_data,
  output logic [CNT_W-1:0]  res_idx,
  output logic              busy,
  output logic              done,
  output sched_state_e      state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and
  // ready are both high; valid is never withdrawn before that edge.

  localparam int LAT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  ntiles_q;
  logic [CNT_W-1:0]  idx_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [CNT_W:0]    idx_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              more_tiles;

  // One extra bit keeps the compare exact even at the maximum tile count.
  always_comb begin
    idx_nxt    = {1'b0, idx_q} + (CNT_W+1)'(1);
    addr_nxt   = addr_q + ADDR_W'(1);
    more_tiles = (idx_nxt < {1'b0, ntiles_q});
  end

  assign res_idx = idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      ntiles_q    <= '0;
      idx_q       <= '0;
      lat_cnt     <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      a_rd_en     <= 1'b0;
      a_rd_addr   <= '0;
      calc_start  <= 1'b0;
      calc_weight <= '0;
      calc_data   <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_base;
            ntiles_q    <= cmd_ntiles;
            calc_weight <= cmd_weight;
            idx_q       <= '0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            if (cmd_ntiles == '0) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              a_rd_en   <= 1'b1;
              a_rd_addr <= cmd_base;
              state     <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          a_rd_en <= 1'b0;
          state   <= S_WAIT_RD;
        end

        // Tile memory returns data one cycle after the strobe.
        S_WAIT_RD: begin
          calc_data  <= a_rd_data;
          calc_start <= 1'b1;
          state      <= S_START;
        end

        S_START: begin
          calc_start <= 1'b0;
          lat_cnt    <= LAT_W'(CALC_LAT - 1);
          state      <= S_COMPUTE;
        end

        S_COMPUTE: begin
          if (lat_cnt == '0) begin
            res_data  <= calc_result;
            res_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            idx_q     <= idx_nxt[CNT_W-1:0];
            addr_q    <= addr_nxt;
            if (more_tiles) begin
              a_rd_en   <= 1'b1;
              a_rd_addr <= addr_nxt;
              state     <= S_FETCH;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end

        S_FIN: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sched.sv
// Randomized bench for calc_sched with a tile memory, a calc_unit stand-in
// and a cycle-level reference model of the job schedule.
module tb_calc_sched;
  import calc_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int CNT_W    = 10;
  localparam int CALC_LAT = 4;
  localparam int TILE_P   = CALC_LAT + 4;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [CNT_W-1:0]  cmd_ntiles;
  logic [S_W-1:0]    cmd_weight;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  a_tile_t           a_rd_data;
  logic              calc_start;
  logic [S_W-1:0]    calc_weight;
  a_tile_t           calc_data;
  y_tile_t           calc_result;
  logic              res_valid;
  logic              res_ready;
  y_tile_t           res_data;
  logic [CNT_W-1:0]  res_idx;
  logic              busy;
  logic              done;
  sched_state_e      dbg_state;

  calc_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .CALC_LAT(CALC_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .cmd_ntiles(cmd_ntiles), .cmd_weight(cmd_weight),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .calc_start(calc_start), .calc_weight(calc_weight), .calc_data(calc_data),
    .calc_result(calc_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .busy(busy), .done(done), .state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [543:0] got, input logic [543:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- data helpers ----------------
  // calc_unit behaviour: each Y element is a 12-bit A slice times a 5-bit S slice.
  function automatic y_tile_t calc_model(input a_tile_t a, input logic [S_W-1:0] w);
    y_tile_t y;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        y[r][c] = {5'b0, a[r][c][11:0]} * {12'b0, w[(r*COLS+c)*5 +: 5]};
    return y;
  endfunction

  function automatic a_tile_t rand_tile();
    a_tile_t t;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        t[r][c] = {$urandom, $urandom};
    return t;
  endfunction

  function automatic y_tile_t rand_y();
    y_tile_t y;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        y[r][c] = 17'($urandom);
    return y;
  endfunction

  function automatic logic [S_W-1:0] rand_w();
    logic [S_W-1:0] w;
    for (int i = 0; i < S_W/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  a_tile_t mem [1 << ADDR_W];

  // ---------------- memory and calc_unit responders ----------------
  bit                rd_pend;
  logic [ADDR_W-1:0] rd_pend_addr;
  bit                st_seen;
  int                lat_k = 0;

  always @(negedge clk) begin
    rd_pend      = a_rd_en;
    rd_pend_addr = a_rd_addr;
    st_seen      = calc_start;
  end

  // Outside the one valid cycle both inputs carry noise.
  always @(posedge clk) begin
    #1;
    a_rd_data = rd_pend ? mem[rd_pend_addr] : rand_tile();
    if (st_seen) lat_k = 1;
    else if (lat_k != 0) lat_k++;
    if (lat_k == CALC_LAT) begin
      calc_result = calc_model(calc_data, calc_weight);
      lat_k = 0;
    end else begin
      calc_result = rand_y();
    end
  end

  // ready_mode: 0 always ready, 1 random, 3 hold low for bp_left valid cycles
  int ready_mode = 0;
  int bp_left = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: res_ready = ($urandom_range(0, 2) != 0);
      3: begin
        res_ready = (bp_left == 0);
        if (res_valid && bp_left > 0) bp_left--;
      end
      default: res_ready = 1'b1;
    endcase
  end

  // ---------------- reference model / scoreboard ----------------
  logic [ADDR_W-1:0] exp_addr_q[$];
  y_tile_t           exp_q[$];
  logic [CNT_W-1:0]  exp_idx_q[$];
  logic [S_W-1:0]    exp_weight;
  bit                exp_busy;
  bit                mon_en = 0;
  int                job_n = 0;
  int                acc_cyc = 0;
  int                rd_exp = -1, start_exp = -1, vld_from = -1, done_exp = -1;

  function automatic void model_clear();
    exp_addr_q.delete();
    exp_q.delete();
    exp_idx_q.delete();
    exp_weight = '0;
    exp_busy   = 1'b0;
    rd_exp = -1; start_exp = -1; vld_from = -1; done_exp = -1;
  endfunction

  function automatic void sched_tile(input int fetch_cyc);
    rd_exp    = fetch_cyc;
    start_exp = fetch_cyc + 2;
    vld_from  = fetch_cyc + 3 + CALC_LAT;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("cmd_ready", cmd_ready, !exp_busy);
      check("busy", busy, exp_busy);
      check("done", done, cyc == done_exp);
      check("a_rd_en", a_rd_en, cyc == rd_exp);
      check("calc_start", calc_start, cyc == start_exp);
      check("res_valid", res_valid, (vld_from >= 0) && (cyc >= vld_from));
      check("calc_weight", calc_weight, exp_weight);
      if (a_rd_en && exp_addr_q.size() > 0)
        check("a_rd_addr", a_rd_addr, exp_addr_q.pop_front());
      if (res_valid && exp_q.size() > 0) begin
        check("res_data", res_data, exp_q[0]);
        check("res_idx", res_idx, exp_idx_q[0]);
      end
      if (cyc == done_exp) exp_busy = 1'b0;
      if (cmd_valid && cmd_ready) begin
        acc_cyc    = cyc;
        exp_busy   = 1'b1;
        exp_weight = cmd_weight;
        if (job_n == 0) done_exp = cyc + 1;
        else sched_tile(cyc + 1);
      end
      if (res_valid && res_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp_idx_q.pop_front());
        if (exp_q.size() == 0) begin
          done_exp = cyc + 1;
          vld_from = -1;
        end else begin
          sched_tile(cyc + 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_calc_start"}, calc_start, 1'b0);
    check({tag, "_a_rd_en"}, a_rd_en, 1'b0);
    check({tag, "_res_idx"}, res_idx, '0);
    check({tag, "_res_data"}, res_data, '0);
    check({tag, "_calc_weight"}, calc_weight, '0);
    check({tag, "_calc_data_zero"}, calc_data == '0, 1'b1);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] n,
                           input int rmode);
    logic [S_W-1:0] w;
    w = rand_w();
    job_n = int'(n);
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(base + ADDR_W'(i));
      exp_q.push_back(calc_model(mem[base + ADDR_W'(i)], w));
      exp_idx_q.push_back(CNT_W'(i));
    end
    ready_mode = rmode;
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_base   = base;
    cmd_ntiles = n;
    cmd_weight = w;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_base   = ADDR_W'($urandom);
    cmd_ntiles = CNT_W'($urandom);
    cmd_weight = rand_w();
  endtask

  task automatic finish_job(input logic [CNT_W-1:0] n, input int rmode, input int extra);
    bit got = 0;
    int dur = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        dur = cyc - acc_cyc;
        break;
      end
    end
    check("job_done_seen", got, 1'b1);
    if (rmode != 1)
      check("job_cycles", dur, (n == 0) ? 1 : int'(n) * TILE_P + 1 + extra);
    check("job_drained", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] n,
                         input int rmode, input bit poke);
    int extra = (rmode == 3) ? bp_left : 0;
    start_job(base, n, rmode);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
    end
    finish_job(n, rmode, extra);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_base   = '0;
    cmd_ntiles = '0;
    cmd_weight = '0;
    res_ready  = 1'b1;
    a_rd_data  = '0;
    calc_result = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = rand_tile();
    model_clear();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1;

    // basic three-tile job
    run_job(10'h010, 10'd3, 0, 0);
    // zero tiles
    run_job(ADDR_W'($urandom), 10'd0, 0, 0);
    // backpressure on tile 0
    bp_left = 10;
    run_job(10'h020, 10'd2, 3, 0);
    // address wrap, command poked mid-job
    run_job(10'h3FF, 10'd2, 0, 1);

    // reset during the compute phase of tile 1
    start_job(10'h080, 10'd3, 0);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (cyc - acc_cyc == TILE_P + 4) break;
    end
    check("midrst_state_before", dbg_state, S_COMPUTE);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    mon_en = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    model_clear();
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1;
    repeat (20) @(posedge clk);
    run_job(10'h040, 10'd2, 0, 0);

    // randomized jobs
    for (int j = 0; j < 8; j++)
      run_job(ADDR_W'($urandom), CNT_W'($urandom_range(0, 5)), $urandom_range(0, 1), 0);

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
